// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: run/pause/load sequencer for the four-digit BCD display counter.
// Turns start/stop/load button levels into single-cycle control strobes.
// It also produces the count-enable tick and the free-running digit scan select.
// Optional build macro: COUNT_SEQ_CTRL_DEBOUNCE_EN adds a 2-flop synchronizer and a
// debouncer in front of each button. Without it, each button has one sampling register.
// Strobe semantics: cnt_en, clr and ld_en are registered and high for exactly one
// cycle. They carry no ready; the consumer must act on every cycle a strobe is high.
// ld_digit/ld_data are valid while ld_en is high and hold their last value otherwise.
module count_seq_ctrl #(
  parameter int CLK_HZ    = 100000000,
  parameter int TICK_HZ   = 1,
  parameter int SCAN_HZ   = 1000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       ld_btn,
  input  logic [1:0] ld_sel,
  input  logic [3:0] ld_val,
  output logic       cnt_en,
  output logic       clr,
  output logic       ld_en,
  output logic [1:0] ld_digit,
  output logic [3:0] ld_data,
  output logic [1:0] scan_sel,
  output logic [3:0] an,
  output logic [1:0] state,
  output logic       ld_err
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int TICK_W   = $clog2(TICK_DIV - 1) + 1;
  localparam int SCAN_W   = $clog2(SCAN_DIV - 1) + 1;
  localparam logic [TICK_W-1:0] TICK_TC = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_TC = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LOAD  = 2'd3
  } state_t;

  // Button bit order everywhere: [0] stop, [1] start, [2] load.
  logic [2:0] btn_raw;
  logic [2:0] btn_lvl;
  logic [2:0] btn_hist;
  logic [2:0] btn_edge;

  assign btn_raw = {ld_btn, start_btn, stop_btn};

`ifdef COUNT_SEQ_CTRL_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES - 1) + 1;
  localparam logic [DB_W-1:0] DB_TC = DB_W'(DB_CYCLES - 1);

  logic [2:0] sync1;
  logic [2:0] sync2;

  // Two-flop synchronizer for the asynchronous button levels.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_db
    logic            lvl;
    logic [DB_W-1:0] cnt;

    // Accept a new level only after DB_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk_in) begin
      if (rst) begin
        lvl <= 1'b0;
        cnt <= '0;
      end else if (sync2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == DB_TC) begin
        lvl <= sync2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end

    assign btn_lvl[i] = lvl;
  end
`else
  // Single sampling register per button.
  always_ff @(posedge clk_in) begin
    if (rst) btn_lvl <= 3'b000;
    else     btn_lvl <= btn_raw;
  end
`endif

  // Edge-detector history; cleared on reset so a held button re-fires once.
  always_ff @(posedge clk_in) begin
    if (rst) btn_hist <= 3'b000;
    else     btn_hist <= btn_lvl;
  end

  assign btn_edge = btn_lvl & ~btn_hist;

  // Only the highest-priority edge in a cycle is a command; the others are dropped.
  logic stop_e, start_e, load_e;
  assign stop_e  = btn_edge[0];
  assign start_e = btn_edge[1] & ~btn_edge[0];
  assign load_e  = btn_edge[2] & ~btn_edge[1] & ~btn_edge[0];

  state_t            st, st_n;
  state_t            ret_st, ret_st_n;
  logic [1:0]        sel_q, sel_n;
  logic [3:0]        val_q, val_n;
  logic [TICK_W-1:0] tick_div, tick_n;
  logic              cnt_en_n, clr_n, ld_en_n, ld_err_n;
  logic [1:0]        ld_digit_n;
  logic [3:0]        ld_data_n;

  // Next-state and next-strobe decode.
  always_comb begin
    st_n       = st;
    ret_st_n   = ret_st;
    sel_n      = sel_q;
    val_n      = val_q;
    tick_n     = tick_div;
    cnt_en_n   = 1'b0;
    clr_n      = 1'b0;
    ld_en_n    = 1'b0;
    ld_digit_n = ld_digit;
    ld_data_n  = ld_data;
    ld_err_n   = ld_err;
    case (st)
      ST_IDLE: begin
        if (start_e) begin
          st_n = ST_RUN;
        end else if (load_e) begin
          st_n     = ST_LOAD;
          ret_st_n = ST_IDLE;
          sel_n    = ld_sel;
          val_n    = ld_val;
        end
      end
      ST_RUN: begin
        if (tick_div == TICK_TC) begin
          tick_n   = '0;
          cnt_en_n = 1'b1;
        end else begin
          tick_n = tick_div + TICK_W'(1);
        end
        if (stop_e) st_n = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (stop_e) begin
          clr_n  = 1'b1;
          tick_n = '0;
          st_n   = ST_IDLE;
        end else if (start_e) begin
          st_n = ST_RUN;
        end else if (load_e) begin
          st_n     = ST_LOAD;
          ret_st_n = ST_PAUSE;
          sel_n    = ld_sel;
          val_n    = ld_val;
        end
      end
      ST_LOAD: begin
        if (val_q <= 4'd9) begin
          ld_en_n    = 1'b1;
          ld_digit_n = sel_q;
          ld_data_n  = val_q;
        end else begin
          ld_err_n = 1'b1;
        end
        st_n = ret_st;
      end
      default: st_n = ST_IDLE;
    endcase
  end

  // State, tick divider, captured load request and registered strobes.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      st       <= ST_IDLE;
      ret_st   <= ST_IDLE;
      sel_q    <= 2'd0;
      val_q    <= 4'd0;
      tick_div <= '0;
      cnt_en   <= 1'b0;
      clr      <= 1'b0;
      ld_en    <= 1'b0;
      ld_digit <= 2'd0;
      ld_data  <= 4'd0;
      ld_err   <= 1'b0;
    end else begin
      st       <= st_n;
      ret_st   <= ret_st_n;
      sel_q    <= sel_n;
      val_q    <= val_n;
      tick_div <= tick_n;
      cnt_en   <= cnt_en_n;
      clr      <= clr_n;
      ld_en    <= ld_en_n;
      ld_digit <= ld_digit_n;
      ld_data  <= ld_data_n;
      ld_err   <= ld_err_n;
    end
  end

  logic [SCAN_W-1:0] scan_div;

  // Free-running scan divider; advances the displayed digit at terminal count.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      scan_div <= '0;
      scan_sel <= 2'd0;
    end else if (scan_div == SCAN_TC) begin
      scan_div <= '0;
      scan_sel <= scan_sel + 2'd1;
    end else begin
      scan_div <= scan_div + SCAN_W'(1);
    end
  end

  assign an    = ~(4'b0001 << scan_sel);
  assign state = st;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl at CLK_HZ=20, TICK_HZ=1, SCAN_HZ=5 (tick every 20 cycles,
// scan step every 4 cycles). A behavioural model tracks expected outputs per cycle.
// Built with COUNT_SEQ_CTRL_DEBOUNCE_EN, only the debounce scenarios run (DB_CYCLES=3).
module tb_count_seq_ctrl;

  localparam int TICK_N = 20;
  localparam int SCAN_N = 4;

  // ---------------- clock / reset / DUT ----------------
  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0, stop_btn = 1'b0, ld_btn = 1'b0;
  logic [1:0] ld_sel = 2'd0;
  logic [3:0] ld_val = 4'd0;
  logic       cnt_en, clr, ld_en, ld_err;
  logic [1:0] ld_digit, scan_sel, state;
  logic [3:0] ld_data, an;

  always #5 clk_in = ~clk_in;

  count_seq_ctrl #(
    .CLK_HZ(20), .TICK_HZ(1), .SCAN_HZ(5), .DB_CYCLES(3)
  ) dut (
    .clk_in(clk_in), .rst(rst),
    .start_btn(start_btn), .stop_btn(stop_btn), .ld_btn(ld_btn),
    .ld_sel(ld_sel), .ld_val(ld_val),
    .cnt_en(cnt_en), .clr(clr), .ld_en(ld_en),
    .ld_digit(ld_digit), .ld_data(ld_data),
    .scan_sel(scan_sel), .an(an), .state(state), .ld_err(ld_err)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Commands: 0 none, 1 stop, 2 start, 3 load. States: 0 IDLE, 1 RUN, 2 PAUSE, 3 LOAD.
  bit [2:0]  m_now, m_prev;      // button levels seen by the input stage, last two cycles
  int        m_state, m_ret, m_run_cycles, m_cycles;
  bit [1:0]  m_sel;
  bit [3:0]  m_val;
  bit        e_cnt, e_clr, e_lden, e_err;
  bit [1:0]  e_dig;
  bit [3:0]  e_dat;

  task automatic model_edge(input bit r, input bit [2:0] b, input bit [1:0] sel,
                            input bit [3:0] val);
    bit [2:0] rising;
    int cmd;
    if (r) begin
      m_now = 0; m_prev = 0; m_state = 0; m_ret = 0; m_run_cycles = 0; m_cycles = 0;
      m_sel = 0; m_val = 0; e_cnt = 0; e_clr = 0; e_lden = 0; e_err = 0;
      e_dig = 0; e_dat = 0;
      return;
    end
    rising = m_now & ~m_prev;
    cmd = rising[0] ? 1 : rising[1] ? 2 : rising[2] ? 3 : 0;
    e_cnt = 0; e_clr = 0; e_lden = 0;
    case (m_state)
      0: begin
        if (cmd == 2) m_state = 1;
        else if (cmd == 3) begin m_ret = 0; m_state = 3; m_sel = sel; m_val = val; end
      end
      1: begin
        m_run_cycles++;
        if (m_run_cycles == TICK_N) begin e_cnt = 1; m_run_cycles = 0; end
        if (cmd == 1) m_state = 2;
      end
      2: begin
        if (cmd == 1) begin e_clr = 1; m_state = 0; m_run_cycles = 0; end
        else if (cmd == 2) m_state = 1;
        else if (cmd == 3) begin m_ret = 2; m_state = 3; m_sel = sel; m_val = val; end
      end
      default: begin
        if (m_val <= 9) begin e_lden = 1; e_dig = m_sel; e_dat = m_val; end
        else e_err = 1;
        m_state = m_ret;
      end
    endcase
    m_prev = m_now;
    m_now = b;
    m_cycles++;
  endtask

  task automatic compare_all();
    int s;
    s = (m_cycles / SCAN_N) % 4;
    check("state", 8'(state), 8'(m_state));
    check("cnt_en", 8'(cnt_en), 8'(e_cnt));
    check("clr", 8'(clr), 8'(e_clr));
    check("ld_en", 8'(ld_en), 8'(e_lden));
    check("ld_digit", 8'(ld_digit), 8'(e_dig));
    check("ld_data", 8'(ld_data), 8'(e_dat));
    check("ld_err", 8'(ld_err), 8'(e_err));
    check("scan_sel", 8'(scan_sel), 8'(s));
    check("an", 8'(an), 8'(4'hF ^ (4'h1 << s)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit r, input bit [2:0] b, input bit [1:0] sel,
                      input bit [3:0] val);
    rst = r; stop_btn = b[0]; start_btn = b[1]; ld_btn = b[2];
    ld_sel = sel; ld_val = val;
    @(posedge clk_in);
    model_edge(r, b, sel, val);
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 2'd0, 4'd0);
  endtask

  // One-cycle button pulse followed by one released cycle.
  task automatic press(input bit [2:0] m, input bit [1:0] sel, input bit [3:0] val);
    step(1'b0, m, sel, val);
    step(1'b0, 3'b000, sel, val);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    int n;
    bit [2:0] lv;
    bit r;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 2'd0, 4'd0);
    check("rst_state", 8'(state), 8'h0);
    check("rst_an", 8'(an), 8'hE);
    check("rst_scan", 8'(scan_sel), 8'h0);
    check("rst_strobes", 8'({cnt_en, clr, ld_en, ld_err}), 8'h0);

`ifdef COUNT_SEQ_CTRL_DEBOUNCE_EN
    // Start input bouncing with 2-cycle glitches: no transition may occur.
    for (int g = 0; g < 4; g++) begin
      rst = 0; start_btn = 1; @(posedge clk_in); model_edge(0, 0, 0, 0); @(negedge clk_in); compare_all();
      @(posedge clk_in); model_edge(0, 0, 0, 0); @(negedge clk_in); compare_all();
      start_btn = 0; @(posedge clk_in); model_edge(0, 0, 0, 0); @(negedge clk_in); compare_all();
      @(posedge clk_in); model_edge(0, 0, 0, 0); @(negedge clk_in); compare_all();
    end
    idle(6);
    check("db_glitch_state", 8'(state), 8'h0);
    // Stable high: RUN must appear exactly 6 cycles after the final rise.
    start_btn = 1;
    n = 0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      n++;
      if (state == 2'd1) seen = 1;
    end
    check("db_run_seen", 8'(seen), 8'h1);
    check("db_latency", 8'(n), 8'd6);
`else
    // Scan walk in IDLE.
    idle(20);

    // Run: three ticks, one every 20 cycles.
    press(3'b010, 2'd0, 4'd0);
    check("run_state", 8'(state), 8'h1);
    seen = 0;
    for (int i = 0; i < 100 && seen < 3; i++) begin
      idle(1);
      if (cnt_en) seen++;
    end
    check("run_ticks", 8'(seen), 8'd3);

    // Stop so PAUSE is entered 5 cycles after the tick.
    idle(3);
    press(3'b001, 2'd0, 4'd0);
    check("pause_state", 8'(state), 8'h2);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      idle(1);
      if (cnt_en) seen++;
    end
    check("pause_quiet", 8'(seen), 8'd0);

    // Resume: fraction kept, next tick after 15 cycles.
    press(3'b010, 2'd0, 4'd0);
    check("resume_state", 8'(state), 8'h1);
    n = 0;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      idle(1);
      n++;
      if (cnt_en) seen = 1;
    end
    check("resume_tick_seen", 8'(seen), 8'h1);
    check("resume_latency", 8'(n), 8'd15);

    // Stop twice: PAUSE, then clr and IDLE.
    press(3'b001, 2'd0, 4'd0);
    press(3'b001, 2'd0, 4'd0);
    check("clr_pulse", 8'(clr), 8'h1);
    check("clr_state", 8'(state), 8'h0);
    idle(2);

    // Load a valid digit from IDLE.
    press(3'b100, 2'd2, 4'd7);
    check("load_state", 8'(state), 8'h3);
    step(1'b0, 3'b000, 2'd2, 4'd7);
    check("load_en", 8'(ld_en), 8'h1);
    check("load_digit", 8'(ld_digit), 8'h2);
    check("load_data", 8'(ld_data), 8'h7);
    check("load_ret", 8'(state), 8'h0);
    idle(2);

    // Load an invalid value: rejected, sticky error.
    press(3'b100, 2'd1, 4'd12);
    step(1'b0, 3'b000, 2'd1, 4'd12);
    check("bad_load_en", 8'(ld_en), 8'h0);
    check("bad_load_err", 8'(ld_err), 8'h1);
    idle(5);
    check("err_sticky", 8'(ld_err), 8'h1);

    // Start and stop together from PAUSE: stop wins.
    press(3'b010, 2'd0, 4'd0);
    press(3'b001, 2'd0, 4'd0);
    press(3'b011, 2'd0, 4'd0);
    check("prio_clr", 8'(clr), 8'h1);
    check("prio_state", 8'(state), 8'h0);

    // Load during RUN is ignored.
    press(3'b010, 2'd0, 4'd0);
    press(3'b100, 2'd1, 4'd5);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      if (ld_en) seen++;
    end
    check("run_load_ignored", 8'(seen), 8'd0);
    check("run_load_state", 8'(state), 8'h1);

    // Button held through reset produces one edge after release.
    step(1'b1, 3'b010, 2'd0, 4'd0);
    step(1'b1, 3'b010, 2'd0, 4'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 3'b010, 2'd0, 4'd0);
    check("held_rst_state", 8'(state), 8'h1);
    idle(2);

    // Randomized levels, values and occasional reset.
    lv = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      for (int j = 0; j < 3; j++)
        if ($urandom_range(0, 29) == 0) lv[j] = ~lv[j];
      r = ($urandom_range(0, 599) == 0);
      step(r, lv, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
